buf_ld_ctrl: RTL

BUF_LD_CTRL -- requirements
Module: buf_ld_ctrl

---
 rtl/buf_ld_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/buf_ld_ctrl.sv
// Ping-pong tile loader: streams upstream words into two buffer banks and
// hands each completed bank to the consumer until it is released.
module buf_ld_ctrl #(
  parameter int BUF_LD_ADDR_WIDTH = 10,
  parameter int BUF_LD_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUF_LD_ADDR_WIDTH:0]   cfg_len,
  input  logic                         cfg_flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BUF_LD_DATA_WIDTH-1:0] s_data,
  output logic                         buf_ld_wr_en,
  output logic                         buf_ld_sel,
  output logic [BUF_LD_ADDR_WIDTH-1:0] buf_ld_addr,
  output logic [BUF_LD_DATA_WIDTH-1:0] buf_ld_data,
  output logic                         buf_ex_sel,
  output logic                         ex_tile_valid,
  input  logic                         ex_tile_done,
  output logic [1:0]                   bank_full
);

  localparam int W = BUF_LD_ADDR_WIDTH;
  localparam int D = BUF_LD_DATA_WIDTH;
  localparam logic [W:0]   LEN_MAX = {1'b1, {W{1'b0}}};
  localparam logic [W:0]   LEN_ONE = (W + 1)'(1);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic         r_ld_sel;
  logic [W-1:0] r_cnt;
  logic [W:0]   r_len_q;
  logic [1:0]   r_full;
  logic         r_ex_sel;
  logic         r_cmt_pend;
  logic         r_cmt_bank;
  logic         r_wr_en;
  logic         r_wr_sel;
  logic [W-1:0] r_wr_addr;
  logic [D-1:0] r_wr_data;

  logic [W:0]   w_len_clamp;
  logic [W:0]   w_len_eff;
  logic         w_ready;
  logic         w_acc;
  logic         w_last;
  logic         w_rel;
  logic [1:0]   w_full_nxt;

  assign w_len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  // First beat of a tile has not latched its length yet, so use the live value.
  assign w_len_eff   = (r_cnt == '0) ? w_len_clamp : r_len_q;
  assign w_ready     = rst_n && !r_full[r_ld_sel] &&
                       ((r_cnt != '0) || (cfg_len != '0)) && !cfg_flush;
  assign w_acc       = s_valid && w_ready;
  assign w_last      = ({1'b0, r_cnt} == (w_len_eff - LEN_ONE));
  assign w_rel       = ex_tile_done && r_full[r_ex_sel];

  // Commit and release always address opposite banks, so both may apply at once.
  always_comb begin
    w_full_nxt = r_full;
    if (r_cmt_pend) w_full_nxt[r_cmt_bank] = 1'b1;
    if (w_rel)      w_full_nxt[r_ex_sel]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_sel   <= 1'b0;
      r_cnt      <= '0;
      r_len_q    <= '0;
      r_full     <= 2'b00;
      r_ex_sel   <= 1'b0;
      r_cmt_pend <= 1'b0;
      r_cmt_bank <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (cfg_flush) begin
      r_ld_sel   <= 1'b0;
      r_cnt      <= '0;
      r_full     <= 2'b00;
      r_ex_sel   <= 1'b0;
      r_cmt_pend <= 1'b0;
      r_cmt_bank <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en    <= w_acc;
      r_full     <= w_full_nxt;
      r_cmt_pend <= 1'b0;
      if (w_rel) r_ex_sel <= ~r_ex_sel;
      if (w_acc) begin
        r_wr_sel  <= r_ld_sel;
        r_wr_addr <= r_cnt;
        r_wr_data <= s_data;
        if (r_cnt == '0) r_len_q <= w_len_clamp;
        // The full flag trails the last write by one cycle via the pending commit.
        if (w_last) begin
          r_cnt      <= '0;
          r_ld_sel   <= ~r_ld_sel;
          r_cmt_pend <= 1'b1;
          r_cmt_bank <= r_ld_sel;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign s_ready       = w_ready;
  assign buf_ld_wr_en  = r_wr_en;
  assign buf_ld_sel    = r_wr_sel;
  assign buf_ld_addr   = r_wr_addr;
  assign buf_ld_data   = r_wr_data;
  assign buf_ex_sel    = r_ex_sel;
  assign ex_tile_valid = r_full[r_ex_sel];
  assign bank_full     = r_full;

endmodule
